// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU ops plus an iterative shift-add MUL, driving the
// register-file write port. Register 0 is never written.
module exec_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic [ADDR_W-1:0] in_dest,
   output logic [ADDR_W-1:0] wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic              wrback,
   output logic              ovf,
   output logic              err
);

   localparam int unsigned MSB   = DATA_W - 1;
   localparam int unsigned CNT_W = $clog2(DATA_W);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_SLT = 4'd5;
   localparam logic [3:0] OP_SLL = 4'd6;
   localparam logic [3:0] OP_SRL = 4'd7;
   localparam logic [3:0] OP_SRA = 4'd8;
   localparam logic [3:0] OP_MUL = 4'd9;

   typedef enum logic {IDLE, MUL} state_t;

   state_t            r_state, w_state_nx;
   logic              r_ready, w_ready_nx;
   logic [ADDR_W-1:0] r_addr,  w_addr_nx;
   logic [DATA_W-1:0] r_data,  w_data_nx;
   logic              r_wr,    w_wr_nx;
   logic              r_ovf,   w_ovf_nx;
   logic              r_err,   w_err_nx;
   logic [CNT_W-1:0]  r_cnt,   w_cnt_nx;
   logic [DATA_W-1:0] r_acc,   w_acc_nx;
   logic [DATA_W-1:0] r_ma,    w_ma_nx;
   logic [DATA_W-1:0] r_mb,    w_mb_nx;
   logic [ADDR_W-1:0] r_mdest, w_mdest_nx;

   logic [DATA_W-1:0] w_add, w_sub, w_alu, w_sum;
   logic [4:0]        w_shamt;
   logic              w_alu_ovf;

   assign w_add   = in_a + in_b;
   assign w_sub   = in_a - in_b;
   assign w_shamt = in_b[4:0];
   // One shift-add step of the multiplier, selected by the current bit of A
   assign w_sum   = r_acc + (r_ma[r_cnt] ? (r_mb << r_cnt) : '0);

   // Single-cycle ALU result and signed-overflow flag
   always_comb begin
      w_alu     = '0;
      w_alu_ovf = 1'b0;
      case (in_op)
         OP_ADD: begin
            w_alu     = w_add;
            w_alu_ovf = (in_a[MSB] == in_b[MSB]) && (w_add[MSB] != in_a[MSB]);
         end
         OP_SUB: begin
            w_alu     = w_sub;
            w_alu_ovf = (in_a[MSB] == ~in_b[MSB]) && (w_sub[MSB] != in_a[MSB]);
         end
         OP_AND:  w_alu = in_a & in_b;
         OP_OR:   w_alu = in_a | in_b;
         OP_XOR:  w_alu = in_a ^ in_b;
         OP_SLT:  w_alu = DATA_W'($signed(in_a) < $signed(in_b));
         OP_SLL:  w_alu = in_a << w_shamt;
         OP_SRL:  w_alu = in_a >> w_shamt;
         OP_SRA:  w_alu = $signed(in_a) >>> w_shamt;
         default: w_alu = '0;
      endcase
   end

   // Next-state and registered-output logic
   always_comb begin
      w_state_nx = r_state;
      w_addr_nx  = r_addr;
      w_data_nx  = r_data;
      w_wr_nx    = 1'b0;
      w_ovf_nx   = 1'b0;
      w_err_nx   = 1'b0;
      w_cnt_nx   = r_cnt;
      w_acc_nx   = r_acc;
      w_ma_nx    = r_ma;
      w_mb_nx    = r_mb;
      w_mdest_nx = r_mdest;
      case (r_state)
         IDLE: begin
            if (in_valid) begin
               if (in_op < OP_MUL) begin
                  w_wr_nx   = (in_dest != '0);
                  w_addr_nx = in_dest;
                  w_data_nx = w_alu;
                  w_ovf_nx  = w_alu_ovf;
               end else if (in_op == OP_MUL) begin
                  w_state_nx = MUL;
                  w_cnt_nx   = '0;
                  w_acc_nx   = '0;
                  w_ma_nx    = in_a;
                  w_mb_nx    = in_b;
                  w_mdest_nx = in_dest;
               end else begin
                  w_err_nx = 1'b1;
               end
            end
         end
         MUL: begin
            w_acc_nx = w_sum;
            w_cnt_nx = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(DATA_W - 1)) begin
               w_state_nx = IDLE;
               w_wr_nx    = (r_mdest != '0);
               w_addr_nx  = r_mdest;
               w_data_nx  = w_sum;
            end
         end
         default: w_state_nx = IDLE;
      endcase
      w_ready_nx = (w_state_nx == IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_ready <= 1'b1;
         r_addr  <= '0;
         r_data  <= '0;
         r_wr    <= 1'b0;
         r_ovf   <= 1'b0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_ma    <= '0;
         r_mb    <= '0;
         r_mdest <= '0;
      end else begin
         r_state <= w_state_nx;
         r_ready <= w_ready_nx;
         r_addr  <= w_addr_nx;
         r_data  <= w_data_nx;
         r_wr    <= w_wr_nx;
         r_ovf   <= w_ovf_nx;
         r_err   <= w_err_nx;
         r_cnt   <= w_cnt_nx;
         r_acc   <= w_acc_nx;
         r_ma    <= w_ma_nx;
         r_mb    <= w_mb_nx;
         r_mdest <= w_mdest_nx;
      end
   end

   assign in_ready = r_ready;
   assign wb_addr  = r_addr;
   assign wb_data  = r_data;
   assign wrback   = r_wr;
   assign ovf      = r_ovf;
   assign err      = r_err;

endmodule

// File: tb/tb_exec_stage.sv
// Bench for exec_stage: transaction-level reference model checked every cycle,
// plus directed vectors with hand-computed literal results.
module tb_exec_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_op = 4'd0;
   logic [31:0] in_a = 32'd0;
   logic [31:0] in_b = 32'd0;
   logic [4:0]  in_dest = 5'd0;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        wrback;
   logic        ovf;
   logic        err;

   int checks = 0;
   int errors = 0;

   exec_stage #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_dest(in_dest),
      .wb_addr(wb_addr), .wb_data(wb_data), .wrback(wrback), .ovf(ovf), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: expected outputs per operation, MUL as a countdown to a*b
   bit          live = 0;
   bit          e_ready, e_wr, e_ovf, e_err, busy;
   logic [4:0]  e_addr, m_dest;
   logic [31:0] e_data, m_prod;
   int          left;

   function automatic void model_alu(input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] r,
                                     output bit o);
      longint s;
      o = 0;
      s = 0;
      case (op)
         4'd0: begin
            r = a + b;
            s = longint'($signed(a)) + longint'($signed(b));
         end
         4'd1: begin
            r = a - b;
            s = longint'($signed(a)) - longint'($signed(b));
         end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd6: r = a << b[4:0];
         4'd7: r = a >> b[4:0];
         default: r = $signed(a) >>> b[4:0];
      endcase
      if (s > 64'sd2147483647 || s < -64'sd2147483648) o = 1;
   endfunction

   always @(posedge clk) begin
      logic [31:0] r;
      bit          o;
      if (rst) begin
         e_ready = 1; e_wr = 0; e_addr = 0; e_data = 0; e_ovf = 0; e_err = 0;
         busy = 0; left = 0; live = 1;
      end else begin
         e_wr = 0; e_err = 0; e_ovf = 0;
         if (busy) begin
            left--;
            if (left == 0) begin
               busy = 0;
               e_wr = (m_dest != 0); e_addr = m_dest; e_data = m_prod;
            end
         end else if (in_valid) begin
            if (in_op < 4'd9) begin
               model_alu(in_op, in_a, in_b, r, o);
               e_wr = (in_dest != 0); e_addr = in_dest; e_data = r; e_ovf = o;
            end else if (in_op == 4'd9) begin
               busy = 1; left = 32; m_prod = in_a * in_b; m_dest = in_dest;
            end else begin
               e_err = 1;
            end
         end
         e_ready = !busy;
      end
   end

   always @(negedge clk) begin
      if (live) begin
         chk("in_ready", 32'(in_ready), 32'(e_ready));
         chk("wrback",   32'(wrback),   32'(e_wr));
         chk("wb_addr",  32'(wb_addr),  32'(e_addr));
         chk("wb_data",  wb_data,       e_data);
         chk("ovf",      32'(ovf),      32'(e_ovf));
         chk("err",      32'(err),      32'(e_err));
      end
   end

   // Called at a negedge; returns at the negedge right after the accept edge
   task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d);
      int n;
      in_valid = 1; in_op = op; in_a = a; in_b = b; in_dest = d;
      n = 0;
      while (!e_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("accept_timeout", 32'(n), 32'd0);
      @(negedge clk);
      in_valid = 0; in_a = $urandom; in_b = $urandom; in_op = 4'($urandom_range(0, 15));
   endtask

   initial begin
      int cyc;
      int seen;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_wrback", 32'(wrback), 32'd0);
      chk("rst_data", wb_data, 32'd0);
      rst = 0;

      send(4'd0, -32'sd2540, 32'd2550, 5'd4);
      chk("add_data", wb_data, 32'd10);
      chk("add_addr", 32'(wb_addr), 32'd4);
      chk("add_wr", 32'(wrback), 32'd1);
      chk("add_ovf", 32'(ovf), 32'd0);
      send(4'd1, 32'h8000_0000, 32'd1, 5'd3);
      chk("sub_data", wb_data, 32'h7FFF_FFFF);
      chk("sub_ovf", 32'(ovf), 32'd1);
      send(4'd0, 32'h7FFF_FFFF, 32'd1, 5'd6);
      chk("addovf_data", wb_data, 32'h8000_0000);
      chk("addovf_ovf", 32'(ovf), 32'd1);
      @(negedge clk);
      chk("pulse_end", 32'(wrback), 32'd0);
      chk("hold_data", wb_data, 32'h8000_0000);

      // MUL with an ADD held upstream until the stage frees up
      send(4'd9, 32'd7, -32'sd3, 5'd5);
      in_valid = 1; in_op = 4'd0; in_a = 32'd100; in_b = 32'd23; in_dest = 5'd7;
      cyc = 0;
      while (wrback !== 1'b1 && cyc < 64) begin
         @(negedge clk);
         cyc++;
      end
      chk("mul_latency", 32'(cyc), 32'd32);
      chk("mul_data", wb_data, -32'sd21);
      chk("mul_addr", 32'(wb_addr), 32'd5);
      chk("mul_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 0;
      chk("held_add", wb_data, 32'd123);
      chk("held_addr", 32'(wb_addr), 32'd7);

      // Back-to-back single-cycle ops
      send(4'd2, 32'h0000_f0f0, 32'h0000_0ff0, 5'd1);
      chk("and", wb_data, 32'h0000_00f0);
      send(4'd3, 32'h0000_f0f0, 32'h0000_0ff0, 5'd2);
      chk("or", wb_data, 32'h0000_fff0);
      send(4'd8, -32'sd8, 32'd2, 5'd3);
      chk("sra", wb_data, -32'sd2);
      send(4'd5, -32'sd1, 32'd1, 5'd8);
      chk("slt", wb_data, 32'd1);
      chk("slt_wr", 32'(wrback), 32'd1);
      send(4'd4, 32'hdead_beef, 32'h1234_5678, 5'd9);
      send(4'd6, 32'h0000_0001, 32'hFFFF_FFE4, 5'd10);
      chk("sll", wb_data, 32'h0000_0010);
      send(4'd7, 32'h8000_0000, 32'd4, 5'd11);
      chk("srl", wb_data, 32'h0800_0000);
      send(4'd5, 32'd5, -32'sd7, 5'd12);
      send(4'd1, 32'd3, 32'd10, 5'd13);
      send(4'd9, 32'h1234_5678, 32'h9abc_def1, 5'd14);
      send(4'd0, 32'd1, 32'd2, 5'd15);
      send(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16);
      repeat (34) @(negedge clk);

      // Register 0 and illegal opcode
      send(4'd0, 32'd1, 32'd1, 5'd0);
      chk("r0_wr", 32'(wrback), 32'd0);
      chk("r0_data", wb_data, 32'd2);
      chk("r0_addr", 32'(wb_addr), 32'd0);
      send(4'd12, 32'd4, 32'd4, 5'd20);
      chk("ill_err", 32'(err), 32'd1);
      chk("ill_wr", 32'(wrback), 32'd0);
      @(negedge clk);
      chk("ill_err_pulse", 32'(err), 32'd0);

      // Reset aborts an in-flight MUL
      send(4'd9, 32'd5, 32'd6, 5'd9);
      repeat (9) @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk("abort_ready", 32'(in_ready), 32'd1);
      chk("abort_wr", 32'(wrback), 32'd0);
      chk("abort_data", wb_data, 32'd0);
      chk("abort_addr", 32'(wb_addr), 32'd0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (wrback) seen++;
      end
      chk("abort_no_wb", 32'(seen), 32'd0);
      send(4'd0, 32'd20, 32'd22, 5'd1);
      chk("post_reset_add", wb_data, 32'd42);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1);
   end

endmodule
